// File: rtl/rb_mult_pkg.sv
// Shared widths and helpers for the row-bypass array multiplier.
package rb_mult_pkg;

   localparam int M_DEF = 8;
   localparam int N_DEF = 8;

   function automatic int pw(input int m, input int n);
      return m + n;
   endfunction

endpackage

// File: rtl/rb_adder_cell.sv
// Full adder with optional row-bypass mux.
// Bypass logic is built only when RB_ROW_BYPASS_EN is defined.
module rb_adder_cell (
   input  logic pp,
   input  logic sum_in,
   input  logic carry_in,
   input  logic bypass,
   output logic sum_out,
   output logic carry_out
);

`ifdef RB_ROW_BYPASS_EN
   logic g_pp;
   logic g_sum;
   logic g_carry;
   logic fa_sum;
   logic fa_carry;

   // Frozen adder inputs keep the cell quiet while its row is skipped
   assign g_pp    = pp & ~bypass;
   assign g_sum   = sum_in & ~bypass;
   assign g_carry = carry_in & ~bypass;

   assign fa_sum   = g_pp ^ g_sum ^ g_carry;
   assign fa_carry = (g_pp & g_sum) | (g_pp & g_carry)
                   | (g_sum & g_carry);

   assign sum_out   = bypass ? sum_in : fa_sum;
   assign carry_out = bypass ? carry_in : fa_carry;
`else
   logic unused_bypass;

   assign unused_bypass = bypass;
   assign sum_out   = pp ^ sum_in ^ carry_in;
   assign carry_out = (pp & sum_in) | (pp & carry_in)
                    | (sum_in & carry_in);
`endif

endmodule

// File: rtl/array_multiplier_row_bypass.sv
// Unsigned m x n array multiplier with registered product.
// Define RB_ROW_BYPASS_EN to skip adder rows whose multiplier bit is 0.
module array_multiplier_row_bypass
   import rb_mult_pkg::*;
#(
   parameter int m = M_DEF,
   parameter int n = N_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [m-1:0]       a,
   input  logic [n-1:0]       x,
   output logic [pw(m,n)-1:0] p
);

   // sv[j] is the m+1 bit partial sum leaving row j, bit 0 weighted 2^j
   logic [n-1:0][m:0] sv;
   logic [n-1:1][m:0] cv;
   logic [n-2:0]      p_low;
   logic [pw(m,n)-1:0] prod;

   assign sv[0] = {1'b0, a & {m{x[0]}}};

   for (genvar j = 1; j < n; j++) begin : g_row
      logic row_bypass;

`ifdef RB_ROW_BYPASS_EN
      assign row_bypass = ~x[j];
`else
      assign row_bypass = 1'b0;
`endif

      // Carries ripple along the row from a zero LSB, so a skipped row
      // forwards an all-zero chain and its sums stay exact.
      assign cv[j][0] = 1'b0;

      for (genvar i = 0; i < m; i++) begin : g_col
         rb_adder_cell u_cell (
            .pp        (a[i] & x[j]),
            .sum_in    (sv[j-1][i+1]),
            .carry_in  (cv[j][i]),
            .bypass    (row_bypass),
            .sum_out   (sv[j][i]),
            .carry_out (cv[j][i+1])
         );
      end

      assign sv[j][m] = cv[j][m];
   end

   for (genvar j = 0; j < n - 1; j++) begin : g_low
      assign p_low[j] = sv[j][0];
   end

   assign prod = {sv[n-1], p_low};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p <= '0;
      end else begin
         p <= prod;
      end
   end

endmodule

// File: tb/tb_array_multiplier_row_bypass.sv
// Randomised self-checking bench for array_multiplier_row_bypass.
// Checks default 8x8 and a 4x6 instance against plain a*x.
module tb_array_multiplier_row_bypass;
   import rb_mult_pkg::*;

   localparam int M  = M_DEF;
   localparam int N  = N_DEF;
   localparam int P  = pw(M, N);
   localparam int M2 = 4;
   localparam int N2 = 6;
   localparam int P2 = pw(M2, N2);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [M-1:0]  a = '0;
   logic [N-1:0]  x = '0;
   logic [P-1:0]  p;
   logic [M2-1:0] a2 = '0;
   logic [N2-1:0] x2 = '0;
   logic [P2-1:0] p2;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   array_multiplier_row_bypass #(.m(M), .n(N)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .x     (x),
      .p     (p)
   );

   array_multiplier_row_bypass #(.m(M2), .n(N2)) u_dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a2),
      .x     (x2),
      .p     (p2)
   );

   task automatic check(input string tag,
                        input logic [P-1:0] got,
                        input logic [P-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, exp);
      end
   endtask

   function automatic logic [P-1:0] mul(input logic [P-1:0] fa,
                                        input logic [P-1:0] fx);
      return fa * fx;
   endfunction

   task automatic step(input string tag,
                       input logic [M-1:0] ta,
                       input logic [N-1:0] tx,
                       input logic [P-1:0] exp);
      @(negedge clk);
      a = ta;
      x = tx;
      @(posedge clk);
      #1;
      check(tag, p, exp);
   endtask

   logic [N-1:0] wz [9];
   logic [M-1:0] ra;
   logic [N-1:0] rx;
   logic [M2-1:0] ra2;
   logic [N2-1:0] rx2;

   initial begin
      wz = '{8'hFF, 8'hFE, 8'hFD, 8'hFB, 8'hF7,
             8'hEF, 8'hDF, 8'hBF, 8'h7F};

      a = 8'hFF;
      x = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      check("rst_hold", p, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_release", p, 16'hFE01);

      for (int k = 0; k < 9; k++) begin
         step("walk_zero", 8'h01, wz[k], {8'h00, wz[k]});
      end

      step("bypass_x00", 8'hA5, 8'h00, 16'h0000);
      step("bypass_x01", 8'hA5, 8'h01, 16'h00A5);
      step("bypass_x80", 8'hA5, 8'h80, 16'h5280);

      step("ext_ff_ff", 8'hFF, 8'hFF, 16'hFE01);
      step("ext_00_ff", 8'h00, 8'hFF, 16'h0000);
      step("ext_80_80", 8'h80, 8'h80, 16'h4000);

      step("pre_async", 8'h37, 8'h5B, mul(8'h37, 8'h5B));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_now", p, 16'h0000);
      @(posedge clk);
      #1;
      check("async_hold", p, 16'h0000);
      @(negedge clk);
      a = 8'hC3;
      x = 8'h3C;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("async_release", p, mul(8'hC3, 8'h3C));

      for (int k = 0; k < 10000; k++) begin
         ra  = M'($urandom);
         rx  = N'($urandom);
         ra2 = M2'($urandom);
         rx2 = N2'($urandom);
         @(negedge clk);
         a  = ra;
         x  = rx;
         a2 = ra2;
         x2 = rx2;
         @(posedge clk);
         #1;
         check("rand_8x8", p, mul(P'(ra), P'(rx)));
         check("rand_4x6", P'(p2), mul(P'(ra2), P'(rx2)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
